// File: rtl/mio_rx_deser.sv
// ----------------------------------------------------------------------------
// mio_rx_deser
//
// Receive-side deserializer for the MIO link. Narrow beats arriving from the
// link sampler are packed into one wide packet and handed to the rx interface
// stage through a single registered output slot.
//
// A packet completes either when BEATS beats have been collected or when the
// frame ends early (io_access_in drops while beats are held). Unfilled slices
// of a short packet read as zero. If the output slot is still occupied when
// a packet completes, the packet is parked in the assembly register. The
// block then raises io_wait_out until the slot frees up.
//
// Parameters
//   IOW            width of one I/O beat
//   MPW            assembled packet width (integer multiple of IOW)
//
// Ports
//   clk            core clock, rising edge
//   nreset         asynchronous active-low reset
//   lsbfirst       1: first beat lands in the least-significant slice
//   io_access_in   beat valid from the link sampler (high for a whole frame)
//   io_packet_in   beat data
//   io_wait_out    backpressure to the link sampler (registered)
//   access_out     assembled packet valid
//   packet_out     assembled packet
//   wait_in        backpressure from the rx interface stage
// ----------------------------------------------------------------------------
module mio_rx_deser #(
    parameter int IOW = 16,
    parameter int MPW = 128
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           lsbfirst,
    input  logic           io_access_in,
    input  logic [IOW-1:0] io_packet_in,
    output logic           io_wait_out,
    output logic           access_out,
    output logic [MPW-1:0] packet_out,
    input  logic           wait_in
);

    localparam int BEATS = MPW / IOW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MPW-1:0]  asm_q, asm_d;
    logic            lsb_q, lsb_d;
    logic            access_q, access_d;
    logic [MPW-1:0]  packet_q, packet_d;
    logic            wait_q, wait_d;

    logic            slot_free;
    logic            accept;
    logic            lsb_eff;
    logic [CW-1:0]   slot;
    logic [MPW-1:0]  merged;
    logic            done;
    logic [MPW-1:0]  done_pkt;

    // State register and datapath flops. Everything clears on reset, so a
    // packet interrupted by reset is discarded.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            asm_q    <= '0;
            lsb_q    <= 1'b0;
            access_q <= 1'b0;
            packet_q <= '0;
            wait_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            lsb_q    <= lsb_d;
            access_q <= access_d;
            packet_q <= packet_d;
            wait_q   <= wait_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        lsb_d    = lsb_q;
        access_d = access_q;
        packet_d = packet_q;
        wait_d   = wait_q;
        done     = 1'b0;
        done_pkt = '0;

        // The slot is free when it is empty or is being consumed this cycle.
        slot_free = !access_q || !wait_in;
        accept    = io_access_in && !wait_q;

        // The first beat of a packet uses the live lsbfirst. Later beats use
        // the value captured with that first beat.
        lsb_eff = (state_q == IDLE) ? lsbfirst : lsb_q;
        slot    = lsb_eff ? cnt_q : (LAST - cnt_q);

        merged = asm_q;
        for (int k = 0; k < BEATS; k++) begin
            if (slot == CW'(k)) begin
                merged[k*IOW +: IOW] = io_packet_in;
            end
        end

        // Consumption empties the slot unless something reloads it below.
        if (slot_free) begin
            access_d = 1'b0;
        end

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        lsb_d = lsbfirst;
                    end
                    if (cnt_q == LAST) begin
                        done     = 1'b1;
                        done_pkt = merged;
                    end else begin
                        asm_d   = merged;
                        cnt_d   = cnt_q + CW'(1);
                        state_d = FILL;
                    end
                end else if (state_q == FILL && !io_access_in) begin
                    // End of frame with a partial packet.
                    done     = 1'b1;
                    done_pkt = asm_q;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    packet_d = asm_q;
                    access_d = 1'b1;
                    asm_d    = '0;
                    wait_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                asm_d   = '0;
                wait_d  = 1'b0;
            end
        endcase

        // A completed packet goes straight to the slot if it is free.
        // Otherwise it is parked in the assembly register and the link
        // sampler is stalled.
        if (done) begin
            cnt_d = '0;
            if (slot_free) begin
                packet_d = done_pkt;
                access_d = 1'b1;
                asm_d    = '0;
                state_d  = IDLE;
            end else begin
                asm_d   = done_pkt;
                wait_d  = 1'b1;
                state_d = HOLD;
            end
        end
    end

    assign io_wait_out = wait_q;
    assign access_out  = access_q;
    assign packet_out  = packet_q;

endmodule

// File: tb/tb_mio_rx_deser.sv
// Self-checking bench for mio_rx_deser at IOW=16, MPW=128.
// A behavioural model runs alongside the design. It keeps the beats of the
// current frame in a queue and builds packets from the slice-placement rule.
// It also tracks the output slot and at most one parked packet.
module tb_mio_rx_deser;

   localparam int IOW   = 16;
   localparam int MPW   = 128;
   localparam int BEATS = MPW / IOW;

   logic           clk;
   logic           nreset;
   logic           lsbfirst;
   logic           io_access_in;
   logic [IOW-1:0] io_packet_in;
   logic           io_wait_out;
   logic           access_out;
   logic [MPW-1:0] packet_out;
   logic           wait_in;

   int errors = 0;
   int checks = 0;

   // Reference model state (values expected after the most recent edge)
   logic [IOW-1:0] mq[$];
   logic           m_lsb;
   logic           m_out_valid;
   logic [MPW-1:0] m_out_data;
   logic           m_pend_valid;
   logic [MPW-1:0] m_pend_data;
   logic           m_accepted;

   mio_rx_deser #(.IOW(IOW), .MPW(MPW)) dut (
      .clk         (clk),
      .nreset      (nreset),
      .lsbfirst    (lsbfirst),
      .io_access_in(io_access_in),
      .io_packet_in(io_packet_in),
      .io_wait_out (io_wait_out),
      .access_out  (access_out),
      .packet_out  (packet_out),
      .wait_in     (wait_in)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [MPW-1:0] got, input logic [MPW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Build a packet from the queued beats: beat k goes to slice k when the
   // first beat is lsb-first, otherwise to slice BEATS-1-k. Missing beats
   // stay zero.
   function automatic logic [MPW-1:0] assemble();
      logic [MPW-1:0] p;
      p = '0;
      for (int k = 0; k < mq.size(); k++) begin
         if (m_lsb) p[k*IOW +: IOW] = mq[k];
         else       p[MPW-(k+1)*IOW +: IOW] = mq[k];
      end
      return p;
   endfunction

   task automatic modelReset();
      mq.delete();
      m_lsb        = 1'b0;
      m_out_valid  = 1'b0;
      m_out_data   = '0;
      m_pend_valid = 1'b0;
      m_pend_data  = '0;
      m_accepted   = 1'b0;
   endtask

   // Drive one cycle of inputs and advance the model over the clock edge.
   // Then compare all three outputs.
   task automatic applyStimulus(input logic acc, input logic [IOW-1:0] data,
                                input logic lsb, input logic win);
      logic           slot_free;
      logic           complete;
      logic [MPW-1:0] pkt;
      logic           n_out_valid, n_pend_valid;
      logic [MPW-1:0] n_out_data, n_pend_data;

      io_access_in = acc;
      io_packet_in = data;
      lsbfirst     = lsb;
      wait_in      = win;

      slot_free  = !m_out_valid || !win;
      m_accepted = acc && !m_pend_valid;
      complete   = 1'b0;
      pkt        = '0;
      if (m_accepted) begin
         if (mq.size() == 0) m_lsb = lsb;
         mq.push_back(data);
         if (mq.size() == BEATS) begin
            pkt = assemble();
            mq.delete();
            complete = 1'b1;
         end
      end else if (!acc && mq.size() > 0) begin
         pkt = assemble();
         mq.delete();
         complete = 1'b1;
      end

      n_out_valid  = m_out_valid;
      n_out_data   = m_out_data;
      n_pend_valid = m_pend_valid;
      n_pend_data  = m_pend_data;
      if (m_pend_valid) begin
         if (slot_free) begin
            n_out_valid  = 1'b1;
            n_out_data   = m_pend_data;
            n_pend_valid = 1'b0;
         end
      end else if (complete) begin
         if (slot_free) begin
            n_out_valid = 1'b1;
            n_out_data  = pkt;
         end else begin
            n_pend_valid = 1'b1;
            n_pend_data  = pkt;
         end
      end else if (slot_free) begin
         n_out_valid = 1'b0;
      end

      @(posedge clk);
      #1;
      m_out_valid  = n_out_valid;
      m_out_data   = n_out_data;
      m_pend_valid = n_pend_valid;
      m_pend_data  = n_pend_data;

      checkOutput("access_out", MPW'(access_out), MPW'(m_out_valid));
      checkOutput("packet_out", packet_out, m_out_data);
      checkOutput("io_wait_out", MPW'(io_wait_out), MPW'(m_pend_valid));
   endtask

   // Pulse reset between edges and confirm every output reads zero.
   task automatic pulseReset();
      io_access_in = 1'b0;
      nreset = 1'b0;
      #2;
      checkOutput("rst_access_out", MPW'(access_out), '0);
      checkOutput("rst_packet_out", packet_out, '0);
      checkOutput("rst_io_wait_out", MPW'(io_wait_out), '0);
      modelReset();
      #2;
      nreset = 1'b1;
   endtask

   initial begin
      int idx;
      logic [MPW-1:0] p1, p2;

      nreset       = 1'b0;
      lsbfirst     = 1'b0;
      io_access_in = 1'b0;
      io_packet_in = '0;
      wait_in      = 1'b0;
      modelReset();

      // Power-on reset; released between edges
      #12;
      checkOutput("por_access_out", MPW'(access_out), '0);
      checkOutput("por_packet_out", packet_out, '0);
      checkOutput("por_io_wait_out", MPW'(io_wait_out), '0);
      nreset = 1'b1;

      // Full packet, lsb first
      $display("[TB] full packet lsbfirst=1");
      for (int i = 1; i <= BEATS; i++) applyStimulus(1'b1, IOW'(i), 1'b1, 1'b0);
      checkOutput("full_lsb_pkt", packet_out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      checkOutput("full_lsb_valid", MPW'(access_out), MPW'(1));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Full packet, msb first; toggling lsbfirst after beat 1 has no effect
      $display("[TB] full packet lsbfirst=0 with toggle");
      for (int i = 1; i <= BEATS; i++) applyStimulus(1'b1, IOW'(i), (i == 1) ? 1'b0 : 1'(i % 2), 1'b0);
      checkOutput("full_msb_pkt", packet_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Partial frame
      $display("[TB] partial frame");
      applyStimulus(1'b1, 16'hAAAA, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'hBBBB, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'hCCCC, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("partial_pkt", packet_out, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
      checkOutput("partial_valid", MPW'(access_out), MPW'(1));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("partial_one_cycle", MPW'(access_out), '0);

      // Backpressure: stream 16 beats with wait_in held high
      $display("[TB] backpressure");
      idx = 1;
      for (int c = 0; c < 40 && idx <= 2 * BEATS; c++) begin
         applyStimulus(1'b1, IOW'(idx), 1'b1, 1'b1);
         if (m_accepted) idx++;
      end
      checkOutput("bp_beats_streamed", MPW'(idx), MPW'(2 * BEATS + 1));
      p1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
      p2 = 128'h0010_000F_000E_000D_000C_000B_000A_0009;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1);
         checkOutput("bp_no_accept", MPW'(m_accepted), '0);
         checkOutput("bp_p1_stable", packet_out, p1);
         checkOutput("bp_wait_high", MPW'(io_wait_out), MPW'(1));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("bp_p2_out", packet_out, p2);
      checkOutput("bp_wait_low", MPW'(io_wait_out), '0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Reset mid-packet, then a clean frame
      $display("[TB] reset mid-packet");
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, IOW'(16'h0100 + i), 1'b1, 1'b0);
      pulseReset();
      for (int i = 1; i <= BEATS; i++) applyStimulus(1'b1, IOW'(16'h0200 + i), 1'b1, 1'b0);
      checkOutput("post_reset_pkt", packet_out, 128'h0208_0207_0206_0205_0204_0203_0202_0201);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Last beat coincides with consumption of the pending output
      $display("[TB] simultaneous completion and consumption");
      for (int i = 1; i <= BEATS; i++) applyStimulus(1'b1, IOW'(16'h0030 + i), 1'b1, 1'b1);
      for (int i = 1; i < BEATS; i++) applyStimulus(1'b1, IOW'(16'h0010 + i), 1'b1, 1'b1);
      applyStimulus(1'b1, 16'h0018, 1'b1, 1'b0);
      checkOutput("simul_pkt", packet_out, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
      checkOutput("simul_wait", MPW'(io_wait_out), '0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic against the model
      $display("[TB] random traffic");
      for (int c = 0; c < 1500; c++) begin
         applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                       IOW'($urandom_range(0, 65535)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
         if (c % 500 == 250) pulseReset();
      end

      // Drain
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
